// File: rtl/sequenciador_multiciclo.sv
// Multicycle control sequencer: steps each instruction through fetch, decode, execute, memory
// and write-back. Optional retired-instruction counter built under SEQ_CONTADOR_RETIRADAS_EN.
module sequenciador_multiciclo (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instrucao,
  input  logic        md_pronto,
  output logic [1:0]  controlePC,
  output logic        Rom_sink_ren,
  output logic        Rom_sink_cen,
  output logic        BR_Hab_Escrita,
  output logic [3:0]  BR_Sel_E_SA,
  output logic [3:0]  BR_Sel_SB,
  output logic        EXcontrole,
  output logic [7:0]  EXconstante,
  output logic        Controle_Mux1,
  output logic        Controle_Mux2,
  output logic [3:0]  ULA_OP,
  output logic        MD_Hab_Escrita,
  output logic        parado,
  output logic        erro_opcode,
  output logic [15:0] instr_retiradas
);

  localparam logic [2:0] StBusca   = 3'd0;
  localparam logic [2:0] StDecod   = 3'd1;
  localparam logic [2:0] StExec    = 3'd2;
  localparam logic [2:0] StMem     = 3'd3;
  localparam logic [2:0] StEscrita = 3'd4;
  localparam logic [2:0] StParado  = 3'd5;

  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpAluR  = 4'h1;
  localparam logic [3:0] OpAluI  = 4'h2;
  localparam logic [3:0] OpLoad  = 4'h3;
  localparam logic [3:0] OpStore = 4'h4;
  localparam logic [3:0] OpJump  = 4'h5;
  localparam logic [3:0] OpHalt  = 4'hF;

  logic [2:0]  state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        erro_q, erro_d;

  logic [3:0] opcode;
  logic       is_undef, is_alu, is_mem, uses_const;

  assign opcode     = ir_q[15:12];
  assign is_undef   = !(opcode inside {OpNop, OpAluR, OpAluI, OpLoad, OpStore, OpJump, OpHalt});
  assign is_alu     = (opcode == OpAluR) || (opcode == OpAluI);
  assign is_mem     = (opcode == OpLoad) || (opcode == OpStore);
  assign uses_const = (opcode == OpAluI) || is_mem;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    erro_d  = erro_q;
    case (state_q)
      StBusca: begin
        state_d = StDecod;
        ir_d    = instrucao;
      end
      StDecod: begin
        if (is_undef) erro_d = 1'b1;
        if (opcode == OpHalt)                     state_d = StParado;
        else if ((opcode == OpNop) || is_undef)   state_d = StBusca;
        else                                      state_d = StExec;
      end
      StExec: begin
        if (is_alu)      state_d = StEscrita;
        else if (is_mem) state_d = StMem;
        else             state_d = StBusca;
      end
      StMem: begin
        if (md_pronto) state_d = (opcode == OpLoad) ? StEscrita : StBusca;
      end
      StEscrita: state_d = StBusca;
      StParado:  state_d = StParado;
      default:   state_d = StBusca;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StBusca;
      ir_q    <= 16'h0000;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      erro_q  <= erro_d;
    end
  end

  // Moore decode from state and IR; only the MEM exit looks at md_pronto.
  always_comb begin
    controlePC     = 2'b00;
    Rom_sink_ren   = 1'b0;
    Rom_sink_cen   = 1'b0;
    BR_Hab_Escrita = 1'b0;
    MD_Hab_Escrita = 1'b0;
    parado         = 1'b0;
    BR_Sel_E_SA    = ir_q[11:8];
    BR_Sel_SB      = ir_q[7:4];
    EXconstante    = ir_q[7:0];
    EXcontrole     = uses_const;
    Controle_Mux1  = uses_const;
    Controle_Mux2  = (opcode == OpLoad);
    ULA_OP         = (opcode == OpAluR) ? ir_q[3:0] : 4'b0000;
    case (state_q)
      StBusca: begin
        Rom_sink_ren = 1'b1;
        Rom_sink_cen = 1'b1;
      end
      StDecod: begin
        if ((opcode == OpNop) || is_undef) controlePC = 2'b01;
      end
      StExec: begin
        if (opcode == OpJump) controlePC = 2'b10;
      end
      StMem: begin
        if (opcode == OpStore) begin
          MD_Hab_Escrita = 1'b1;
          if (md_pronto) controlePC = 2'b01;
        end
      end
      StEscrita: begin
        BR_Hab_Escrita = 1'b1;
        controlePC     = 2'b01;
      end
      StParado: parado = 1'b1;
      default: ;
    endcase
  end

  // Visible already in the decode cycle that detects it, held until reset.
  assign erro_opcode = erro_q | ((state_q == StDecod) && is_undef);

`ifdef SEQ_CONTADOR_RETIRADAS_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = (controlePC != 2'b00) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= 16'h0000;
    else        cnt_q <= cnt_d;
  end

  assign instr_retiradas = cnt_q;
`else
  assign instr_retiradas = 16'h0000;
`endif

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Directed bench for sequenciador_multiciclo: per-cycle control vectors checked against
// hand-computed expectations, sampled mid-cycle on the falling edge.
module tb_sequenciador_multiciclo;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instrucao = 16'h0000;
  logic        md_pronto = 1'b0;
  logic [1:0]  controlePC;
  logic        Rom_sink_ren, Rom_sink_cen, BR_Hab_Escrita;
  logic [3:0]  BR_Sel_E_SA, BR_Sel_SB, ULA_OP;
  logic        EXcontrole, Controle_Mux1, Controle_Mux2, MD_Hab_Escrita, parado, erro_opcode;
  logic [7:0]  EXconstante;
  logic [15:0] instr_retiradas;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  sequenciador_multiciclo dut (
    .clock          (clock),
    .reset          (reset),
    .instrucao      (instrucao),
    .md_pronto      (md_pronto),
    .controlePC     (controlePC),
    .Rom_sink_ren   (Rom_sink_ren),
    .Rom_sink_cen   (Rom_sink_cen),
    .BR_Hab_Escrita (BR_Hab_Escrita),
    .BR_Sel_E_SA    (BR_Sel_E_SA),
    .BR_Sel_SB      (BR_Sel_SB),
    .EXcontrole     (EXcontrole),
    .EXconstante    (EXconstante),
    .Controle_Mux1  (Controle_Mux1),
    .Controle_Mux2  (Controle_Mux2),
    .ULA_OP         (ULA_OP),
    .MD_Hab_Escrita (MD_Hab_Escrita),
    .parado         (parado),
    .erro_opcode    (erro_opcode),
    .instr_retiradas(instr_retiradas)
  );

  always #5 clock = ~clock;

  // {ren, cen, br_we, md_we, mux1, mux2, excontrole, parado, controlePC}
  function automatic logic [9:0] ctl();
    return {Rom_sink_ren, Rom_sink_cen, BR_Hab_Escrita, MD_Hab_Escrita, Controle_Mux1,
            Controle_Mux2, EXcontrole, parado, controlePC};
  endfunction

  function automatic logic [15:0] exp_cnt(input logic [15:0] n);
`ifdef SEQ_CONTADOR_RETIRADAS_EN
    return n;
`else
    return 16'h0000 & n;
`endif
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk_cnt++;
    if (ctl() !== 10'b1100000000) $display("FAIL reset_ctl got=%b exp=%b", ctl(), 10'b1100000000);
    else pass_cnt++;
    chk_cnt++;
    if ({ULA_OP, BR_Sel_E_SA, BR_Sel_SB, EXconstante, erro_opcode, instr_retiradas} !== 37'd0)
      $display("FAIL reset_fields ula=%h sa=%h sb=%h k=%h err=%b cnt=%h exp=all zero",
               ULA_OP, BR_Sel_E_SA, BR_Sel_SB, EXconstante, erro_opcode, instr_retiradas);
    else pass_cnt++;
    reset = 1'b1;
  endtask

  // Each instruction task starts sitting mid-cycle in BUSCA and ends in the next BUSCA.
  task automatic test_alu_r();
    logic [9:0] ev [1:4];
    ev[1] = 10'b0000000000; ev[2] = 10'b0000000000;
    ev[3] = 10'b0010000001; ev[4] = 10'b1100000000;
    instrucao = 16'h1123;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock); #1;
      chk_cnt++;
      if (ctl() !== ev[i]) $display("FAIL alu_r_ctl c%0d got=%b exp=%b", i, ctl(), ev[i]);
      else pass_cnt++;
      if (i == 3) begin
        chk_cnt++;
        if ({ULA_OP, BR_Sel_E_SA, BR_Sel_SB} !== 12'h312)
          $display("FAIL alu_r_fields got=%h exp=312", {ULA_OP, BR_Sel_E_SA, BR_Sel_SB});
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (instr_retiradas !== exp_cnt(16'd1))
      $display("FAIL alu_r_cnt got=%h exp=%h", instr_retiradas, exp_cnt(16'd1));
    else pass_cnt++;
  endtask

  task automatic test_load_wait();
    logic [9:0] ev [1:8];
    logic       md [1:8];
    for (int i = 1; i <= 6; i++) ev[i] = 10'b0000111000;
    ev[7] = 10'b0010111001; ev[8] = 10'b1100111000;
    // md_pronto high in DECOD/EXEC must be ignored; low for three MEM cycles
    md[1] = 1; md[2] = 1; md[3] = 0; md[4] = 0; md[5] = 0; md[6] = 1; md[7] = 1; md[8] = 1;
    instrucao = 16'h3205;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      md_pronto = md[i];
      #1;
      chk_cnt++;
      if (ctl() !== ev[i]) $display("FAIL load_ctl c%0d got=%b exp=%b", i, ctl(), ev[i]);
      else pass_cnt++;
      if (i == 2) begin
        chk_cnt++;
        if ({EXconstante, ULA_OP} !== 12'h050)
          $display("FAIL load_fields got=%h exp=050", {EXconstante, ULA_OP});
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (instr_retiradas !== exp_cnt(16'd2))
      $display("FAIL load_cnt got=%h exp=%h", instr_retiradas, exp_cnt(16'd2));
    else pass_cnt++;
  endtask

  task automatic test_store_ready();
    logic [9:0] ev [1:4];
    ev[1] = 10'b0000101000; ev[2] = 10'b0000101000;
    ev[3] = 10'b0001101001; ev[4] = 10'b1100101000;
    instrucao = 16'h4107;
    md_pronto = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock); #1;
      chk_cnt++;
      if (ctl() !== ev[i]) $display("FAIL store_ctl c%0d got=%b exp=%b", i, ctl(), ev[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_jump_undef_halt();
    logic [9:0] ev [1:3];
    ev[1] = 10'b0000000000; ev[2] = 10'b0000000010; ev[3] = 10'b1100000000;
    instrucao = 16'h5010;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock); #1;
      chk_cnt++;
      if (ctl() !== ev[i]) $display("FAIL jump_ctl c%0d got=%b exp=%b", i, ctl(), ev[i]);
      else pass_cnt++;
    end
    instrucao = 16'h9000;
    @(negedge clock); #1;
    chk_cnt++;
    if ({ctl(), erro_opcode} !== 11'b00000000011)
      $display("FAIL undef_decod got=%b exp=%b", {ctl(), erro_opcode}, 11'b00000000011);
    else pass_cnt++;
    @(negedge clock); #1;
    chk_cnt++;
    if ({ctl(), erro_opcode} !== 11'b11000000001)
      $display("FAIL undef_sticky got=%b exp=%b", {ctl(), erro_opcode}, 11'b11000000001);
    else pass_cnt++;
    chk_cnt++;
    if (instr_retiradas !== exp_cnt(16'd5))
      $display("FAIL undef_cnt got=%h exp=%h", instr_retiradas, exp_cnt(16'd5));
    else pass_cnt++;
    instrucao = 16'hF000;
    @(negedge clock); #1;
    chk_cnt++;
    if (ctl() !== 10'b0000000000) $display("FAIL halt_decod got=%b exp=0000000000", ctl());
    else pass_cnt++;
    for (int i = 0; i < 21; i++) begin
      @(negedge clock); #1;
      chk_cnt++;
      if (ctl() !== 10'b0000000100) $display("FAIL halt_hold c%0d got=%b exp=0000000100", i, ctl());
      else pass_cnt++;
    end
    chk_cnt++;
    if (instr_retiradas !== exp_cnt(16'd5))
      $display("FAIL halt_cnt got=%h exp=%h", instr_retiradas, exp_cnt(16'd5));
    else pass_cnt++;
    reset = 1'b0;
    #1;
    chk_cnt++;
    if ({ctl(), erro_opcode, instr_retiradas} !== {10'b1100000000, 1'b0, 16'h0000})
      $display("FAIL halt_reset got=%b err=%b cnt=%h exp=1100000000 err=0 cnt=0000",
               ctl(), erro_opcode, instr_retiradas);
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset_in_mem();
    logic [9:0] ev [1:4];
    ev[1] = 10'b0000101000; ev[2] = 10'b0000101000;
    ev[3] = 10'b0001101000; ev[4] = 10'b0001101000;
    instrucao = 16'h4107;
    md_pronto = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock); #1;
      chk_cnt++;
      if (ctl() !== ev[i]) $display("FAIL store_wait_ctl c%0d got=%b exp=%b", i, ctl(), ev[i]);
      else pass_cnt++;
    end
    reset = 1'b0;
    #1;
    chk_cnt++;
    if (ctl() !== 10'b1100000000)
      $display("FAIL reset_mem_ctl got=%b exp=1100000000", ctl());
    else pass_cnt++;
    @(negedge clock);
    md_pronto = 1'b1;
    reset = 1'b1;
    #1;
    chk_cnt++;
    if ({ctl(), instr_retiradas} !== {10'b1100000000, 16'h0000})
      $display("FAIL reset_mem_after got=%b cnt=%h exp=1100000000 cnt=0000", ctl(), instr_retiradas);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_alu_r();
    test_load_wait();
    test_store_ready();
    test_jump_undef_halt();
    test_reset_in_mem();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sequenciador_multiciclo.md
# sequenciador_multiciclo

Multicycle control sequencer for the 16-bit processor datapath. Replaces the single-cycle decode of the current control block with a state machine that steps each instruction through fetch, decode, execute, memory and write-back. It drives the PC, instruction ROM, register bank, ALU/mux selects and data-memory write enable. It also stalls on a data-memory ready handshake.

## Interface
Parameters:
- none

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- instrucao  in  16  instruction word from IF (ROM data, valid 1 cycle after ren/cen)
- md_pronto  in  1  data memory ready; completes a LOAD/STORE access
- controlePC  out  2  00 hold, 01 PC+1, 10 load jump target
- Rom_sink_ren  out  1  ROM read enable
- Rom_sink_cen  out  1  ROM chip enable
- BR_Hab_Escrita  out  1  register bank write enable
- BR_Sel_E_SA  out  4  write/read-A register select = IR[11:8]
- BR_Sel_SB  out  4  read-B register select = IR[7:4]
- EXcontrole  out  1  1 = sign-extend constant
- EXconstante  out  8  IR[7:0]
- Controle_Mux1  out  1  ALU B operand: 0 register B, 1 extended constant
- Controle_Mux2  out  1  write-back source: 0 ALU, 1 data memory
- ULA_OP  out  4  ALU operation = IR[3:0] for ALU-R, 4'b0000 (add) otherwise
- MD_Hab_Escrita  out  1  data memory write enable
- parado  out  1  HALT reached
- erro_opcode  out  1  sticky: undefined opcode decoded
- instr_retiradas  out  16  retired-instruction count (see Configuration)

## Operation
- Opcode IR[15:12]:
  - 0 NOP
  - 1 ALU-R (rd = ra op rb)
  - 2 ALU-I (rd = ra + ext(const))
  - 3 LOAD
  - 4 STORE
  - 5 JUMP
  - F HALT
  - others are undefined: executed as NOP and set erro_opcode.
- IR (16 bit) is loaded from instrucao on the clock edge leaving BUSCA. All field outputs derive from IR, not instrucao.
- States: BUSCA, DECOD, EXEC, MEM, ESCRITA, PARADO.
- BUSCA: ren=cen=1; next state DECOD.
- DECOD:
  - NOP or undefined → BUSCA, controlePC=01.
  - HALT → PARADO.
  - else → EXEC.
- EXEC: ALU selects valid.
  - ALU-R/ALU-I → ESCRITA.
  - LOAD/STORE → MEM.
  - JUMP → BUSCA, controlePC=10.
- MEM:
  - STORE: MD_Hab_Escrita=1 every cycle until md_pronto=1; then → BUSCA, controlePC=01.
  - LOAD: wait for md_pronto; then → ESCRITA.
- ESCRITA: BR_Hab_Escrita=1 for exactly one cycle; Mux2=1 for LOAD else 0; controlePC=01; → BUSCA.
- PARADO: all enables 0, controlePC=00, parado=1. Exit only via reset.
- controlePC is non-zero for exactly one cycle per retired instruction; 00 otherwise.
- Mux1=1 and EXcontrole=1 for ALU-I/LOAD/STORE. LOAD/STORE address = ra + ext(const).

## Timing
- Reset (async, reset=0):
  - state=BUSCA, IR=0.
  - All outputs 0, except Rom_sink_ren=Rom_sink_cen=1 as decoded from BUSCA.
  - erro_opcode=0, instr_retiradas=0.
- Outputs are Moore (decoded from state+IR), except MEM exit, which depends combinationally on md_pronto.
- Cycles per instruction:
  - NOP 2, JUMP 3, ALU 4.
  - STORE 4+w, LOAD 5+w, where w = cycles md_pronto is low in MEM.
  - HALT: parado rises 2 cycles after BUSCA.
- md_pronto already high on MEM entry: w=0.
- md_pronto outside MEM: ignored.
- Reset asserted mid-instruction: the instruction is abandoned with no register or memory write after the reset edge; PC is not advanced.

## Configuration
- SEQ_CONTADOR_RETIRADAS_EN defined:
  - instr_retiradas increments on every cycle where controlePC≠00.
  - The count wraps FFFF→0000.
  - HALT is not counted.
- SEQ_CONTADOR_RETIRADAS_EN undefined: instr_retiradas tied to 16'h0000 and no counter register is built.

## Test plan
- Reset release, ROM delivers 16'h1123 (ALU-R, rd=1, rb=2, op=3):
  - DECOD, EXEC, ESCRITA follow BUSCA.
  - In ESCRITA: ULA_OP=3, Mux1=0, Mux2=0, BR_Hab_Escrita=1 for 1 cycle, controlePC=01.
  - 4 cycles total.
- 16'h3205 (LOAD) with md_pronto low for 3 MEM cycles:
  - Mux1=1, EXconstante=05.
  - ESCRITA with Mux2=1.
  - 8 cycles total.
- 16'h4107 (STORE) with md_pronto high on entry: MD_Hab_Escrita=1 for exactly 1 cycle, no BR write, 4 cycles.
- 16'h5010 (JUMP): controlePC=10 in EXEC, 3 cycles. Then 16'hF000: parado=1 and stays 1 for 20 cycles with all enables 0.
- 16'h9000:
  - erro_opcode=1, controlePC=01 at DECOD.
  - With the macro on, instr_retiradas increments by 1; after reset it returns to 0.
- Reset pulsed low during MEM of a STORE: MD_Hab_Escrita drops immediately, state=BUSCA, no PC advance.
